// File: rtl/buff_ip_to_nn_stream.sv
// Captures a UDP payload frame plus its source addressing, then streams it to the NN input
// memory as fixed-point pixel beats. Optional shadow frame buffer: BUFF_IP_TO_NN_STREAM_PINGPONG_EN.
`timescale 1ns/1ps
module buff_ip_to_nn_stream #(
  parameter int IMG_ROWS   = 28,
  parameter int IMG_COLS   = 28,
  parameter int CHANNELS   = 1,
  parameter int LANES      = 1,
  parameter int DATA_W     = 18,
  parameter int FRAC_SHIFT = 2,
  localparam int USER_DATA_BYTES = IMG_ROWS * IMG_COLS * CHANNELS,
  localparam int ROW_W = (IMG_ROWS > 1) ? $clog2(IMG_ROWS) : 1,
  localparam int COL_W = (IMG_COLS > 1) ? $clog2(IMG_COLS) : 1,
  localparam int CH_W  = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                           ACLK,
  input  logic                           ARESET,
  input  logic [0:USER_DATA_BYTES*8-1]   DATA_FRAME_IP,
  input  logic [0:31]                    SRC_IP_ADDRESS_IP,
  input  logic [0:47]                    SRC_MAC_ADDRESS_IP,
  input  logic [0:15]                    SRC_UDP_PORT_IP,
  input  logic                           FRAME_READY,
  output logic                           FRAME_ACCEPT,
  output logic                           FRAME_DROP,
  output logic                           BUSY,
  output logic [0:31]                    SRC_IP_ADDRESS_NN,
  output logic [0:47]                    SRC_MAC_ADDRESS_NN,
  output logic [0:15]                    SRC_UDP_PORT_NN,
  output logic [LANES*DATA_W-1:0]        W_DATA,
  output logic                           W_EN,
  input  logic                           W_READY,
  output logic [CH_W-1:0]                W_CH,
  output logic [ROW_W-1:0]               W_ROW,
  output logic [COL_W-1:0]               W_COL,
  output logic                           W_DONE
);
  localparam int PTR_W = (USER_DATA_BYTES > 1) ? $clog2(USER_DATA_BYTES) : 1;
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_COLS - LANES);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_ROWS - 1);
  localparam logic [CH_W-1:0]  CH_LAST  = CH_W'(CHANNELS - 1);

  // IDLE: waiting for a frame | STREAM: emitting beats | DONE: one-cycle W_DONE
  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;
  state_t state, next_state;

  logic [7:0]       frame_buf [USER_DATA_BYTES];
  logic [PTR_W-1:0] ptr;
  logic             capture_main, accept, drop, beat, last_beat;
`ifdef BUFF_IP_TO_NN_STREAM_PINGPONG_EN
  logic [7:0]       shadow_buf [USER_DATA_BYTES];
  logic [0:31]      shadow_ip;
  logic [0:47]      shadow_mac;
  logic [0:15]      shadow_port;
  logic             shadow_full, capture_shadow, load_shadow;
`endif

  assign beat      = W_EN && W_READY;
  assign last_beat = beat && (W_COL == COL_LAST) && (W_ROW == ROW_LAST) && (W_CH == CH_LAST);

  always_ff @(posedge ACLK) begin
    if (ARESET) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state   = state;
    capture_main = 1'b0;
    accept       = 1'b0;
    drop         = 1'b0;
    W_EN         = 1'b0;
    W_DONE       = 1'b0;
`ifdef BUFF_IP_TO_NN_STREAM_PINGPONG_EN
    capture_shadow = 1'b0;
    load_shadow    = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        if (FRAME_READY) begin
          capture_main = 1'b1;
          accept       = 1'b1;
          next_state   = STREAM;
        end
      end
      STREAM: begin
        W_EN = 1'b1;
        if (last_beat) next_state = DONE;
        if (FRAME_READY) begin
`ifdef BUFF_IP_TO_NN_STREAM_PINGPONG_EN
          if (!shadow_full) begin
            capture_shadow = 1'b1;
            accept         = 1'b1;
          end else begin
            drop = 1'b1;
          end
`else
          drop = 1'b1;
`endif
        end
      end
      DONE: begin
        W_DONE     = 1'b1;
        next_state = IDLE;
`ifdef BUFF_IP_TO_NN_STREAM_PINGPONG_EN
        // A full shadow is still vacating at this edge, so a new frame cannot land anywhere.
        if (shadow_full) begin
          load_shadow = 1'b1;
          next_state  = STREAM;
          drop        = FRAME_READY;
        end else
`endif
        if (FRAME_READY) begin
          capture_main = 1'b1;
          accept       = 1'b1;
          next_state   = STREAM;
        end
      end
      default: next_state = IDLE;
    endcase
`ifdef BUFF_IP_TO_NN_STREAM_PINGPONG_EN
    BUSY = (state != IDLE) || shadow_full;
`else
    BUSY = (state != IDLE);
`endif
  end

  always_comb begin
    W_DATA = '0;
    for (int k = 0; k < LANES; k++)
      W_DATA[k*DATA_W +: DATA_W] = DATA_W'(frame_buf[ptr + PTR_W'(k)]) << FRAC_SHIFT;
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      for (int i = 0; i < USER_DATA_BYTES; i++) frame_buf[i] <= '0;
      SRC_IP_ADDRESS_NN  <= '0;
      SRC_MAC_ADDRESS_NN <= '0;
      SRC_UDP_PORT_NN    <= '0;
      FRAME_ACCEPT       <= 1'b0;
      FRAME_DROP         <= 1'b0;
      W_CH               <= '0;
      W_ROW              <= '0;
      W_COL              <= '0;
      ptr                <= '0;
`ifdef BUFF_IP_TO_NN_STREAM_PINGPONG_EN
      for (int i = 0; i < USER_DATA_BYTES; i++) shadow_buf[i] <= '0;
      shadow_ip   <= '0;
      shadow_mac  <= '0;
      shadow_port <= '0;
      shadow_full <= 1'b0;
`endif
    end else begin
      FRAME_ACCEPT <= accept;
      FRAME_DROP   <= drop;
      if (capture_main) begin
        for (int i = 0; i < USER_DATA_BYTES; i++) frame_buf[i] <= DATA_FRAME_IP[i*8 +: 8];
        SRC_IP_ADDRESS_NN  <= SRC_IP_ADDRESS_IP;
        SRC_MAC_ADDRESS_NN <= SRC_MAC_ADDRESS_IP;
        SRC_UDP_PORT_NN    <= SRC_UDP_PORT_IP;
      end
`ifdef BUFF_IP_TO_NN_STREAM_PINGPONG_EN
      if (capture_shadow) begin
        for (int i = 0; i < USER_DATA_BYTES; i++) shadow_buf[i] <= DATA_FRAME_IP[i*8 +: 8];
        shadow_ip   <= SRC_IP_ADDRESS_IP;
        shadow_mac  <= SRC_MAC_ADDRESS_IP;
        shadow_port <= SRC_UDP_PORT_IP;
        shadow_full <= 1'b1;
      end
      if (load_shadow) begin
        frame_buf          <= shadow_buf;
        SRC_IP_ADDRESS_NN  <= shadow_ip;
        SRC_MAC_ADDRESS_NN <= shadow_mac;
        SRC_UDP_PORT_NN    <= shadow_port;
        shadow_full        <= 1'b0;
      end
`endif
      // Indices wrap to zero on the final beat, so DONE and the next frame start at 0.
      if (beat) begin
        ptr <= last_beat ? '0 : ptr + PTR_W'(LANES);
        if (W_COL == COL_LAST) begin
          W_COL <= '0;
          if (W_ROW == ROW_LAST) begin
            W_ROW <= '0;
            W_CH  <= (W_CH == CH_LAST) ? '0 : W_CH + CH_W'(1);
          end else begin
            W_ROW <= W_ROW + ROW_W'(1);
          end
        end else begin
          W_COL <= W_COL + COL_W'(LANES);
        end
      end
    end
  end
endmodule

// File: tb/tb_buff_ip_to_nn_stream.sv
// Bench for buff_ip_to_nn_stream: a 28x28x1 instance and a 4x8x3 four-lane instance,
// checked against a queue of expected beats built from byte-position arithmetic.
`timescale 1ns/1ps
module tb_buff_ip_to_nn_stream;
`ifdef BUFF_IP_TO_NN_STREAM_PINGPONG_EN
  localparam bit PP = 1'b1;
`else
  localparam bit PP = 1'b0;
`endif
  localparam int A_BYTES = 784;
  localparam int B_BYTES = 96;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic [0:A_BYTES*8-1] a_frame;
  logic [0:31] a_ip, a_nn_ip;
  logic [0:47] a_mac, a_nn_mac;
  logic [0:15] a_port, a_nn_port;
  logic a_rst, a_fr, a_acc, a_drop, a_busy, a_wen, a_ready, a_wdone;
  logic [17:0] a_wdata;
  logic [0:0] a_wch;
  logic [4:0] a_wrow, a_wcol;

  logic [0:B_BYTES*8-1] b_frame;
  logic [0:31] b_ip, b_nn_ip;
  logic [0:47] b_mac, b_nn_mac;
  logic [0:15] b_port, b_nn_port;
  logic b_rst, b_fr, b_acc, b_drop, b_busy, b_wen, b_ready, b_wdone;
  logic [71:0] b_wdata;
  logic [1:0] b_wch, b_wrow;
  logic [2:0] b_wcol;

  buff_ip_to_nn_stream dut_a (
    .ACLK(clk), .ARESET(a_rst), .DATA_FRAME_IP(a_frame),
    .SRC_IP_ADDRESS_IP(a_ip), .SRC_MAC_ADDRESS_IP(a_mac), .SRC_UDP_PORT_IP(a_port),
    .FRAME_READY(a_fr), .FRAME_ACCEPT(a_acc), .FRAME_DROP(a_drop), .BUSY(a_busy),
    .SRC_IP_ADDRESS_NN(a_nn_ip), .SRC_MAC_ADDRESS_NN(a_nn_mac), .SRC_UDP_PORT_NN(a_nn_port),
    .W_DATA(a_wdata), .W_EN(a_wen), .W_READY(a_ready), .W_CH(a_wch), .W_ROW(a_wrow),
    .W_COL(a_wcol), .W_DONE(a_wdone));

  buff_ip_to_nn_stream #(.IMG_ROWS(4), .IMG_COLS(8), .CHANNELS(3), .LANES(4)) dut_b (
    .ACLK(clk), .ARESET(b_rst), .DATA_FRAME_IP(b_frame),
    .SRC_IP_ADDRESS_IP(b_ip), .SRC_MAC_ADDRESS_IP(b_mac), .SRC_UDP_PORT_IP(b_port),
    .FRAME_READY(b_fr), .FRAME_ACCEPT(b_acc), .FRAME_DROP(b_drop), .BUSY(b_busy),
    .SRC_IP_ADDRESS_NN(b_nn_ip), .SRC_MAC_ADDRESS_NN(b_nn_mac), .SRC_UDP_PORT_NN(b_nn_port),
    .W_DATA(b_wdata), .W_EN(b_wen), .W_READY(b_ready), .W_CH(b_wch), .W_ROW(b_wrow),
    .W_COL(b_wcol), .W_DONE(b_wdone));

  typedef struct {
    int          ch, row, col;
    logic [71:0] data;
    logic [31:0] ip;
    logic [47:0] mac;
    logic [15:0] port;
    bit          last;
  } beat_t;

  beat_t sb[2][$];
  bit    done_due[2];
  int    beats[2];
  int    n_checks = 0;
  int    n_fail = 0;
  bit    rmode = 1'b0;
  int    rcnt = 0;

  task automatic chk(input string nm, input logic [271:0] act, input logic [271:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int pbyte(input int pat, input int i);
    case (pat)
      0:       return i % 27;
      1:       return i % 256;
      default: return (i * 7 + 3) % 256;
    endcase
  endfunction

  // Expected beats: beat j covers bytes j*L..j*L+L-1, located by plain division.
  task automatic push_frame(input int w, input int r, input int c, input int nch, input int l,
                            input int pat, input logic [31:0] ip, input logic [47:0] mac,
                            input logic [15:0] port);
    int n;
    n = r * c * nch / l;
    for (int j = 0; j < n; j++) begin
      beat_t e;
      int rem;
      e.ch  = (j * l) / (r * c);
      rem   = (j * l) % (r * c);
      e.row = rem / c;
      e.col = rem % c;
      e.data = '0;
      for (int k = 0; k < l; k++) e.data[k*18 +: 18] = 18'(pbyte(pat, j * l + k) * 4);
      e.ip = ip; e.mac = mac; e.port = port;
      e.last = (j == n - 1);
      sb[w].push_back(e);
    end
  endtask

  task automatic mon(input int w, input logic wen, input logic rdy, input logic wdone,
                     input int ch, input int row, input int col, input logic [71:0] data,
                     input logic [31:0] ip, input logic [47:0] mac, input logic [15:0] port);
    beat_t e;
    if (done_due[w]) begin
      chk("done_pulse", {wdone, wen}, 2'b10);
      chk("done_idx", {ch, row, col}, '0);
      done_due[w] = 1'b0;
    end else if (wdone) begin
      chk("spurious_done", wdone, 1'b0);
    end
    if (wen) begin
      if (sb[w].size() == 0) begin
        chk("unexpected_beat", wen, 1'b0);
      end else begin
        e = sb[w][0];
        chk("beat_idx", {ch, row, col}, {e.ch, e.row, e.col});
        chk("beat_data", data, e.data);
        chk("beat_src", {ip, mac, port}, {e.ip, e.mac, e.port});
        if (rdy) begin
          void'(sb[w].pop_front());
          beats[w]++;
          if (e.last) done_due[w] = 1'b1;
        end
      end
    end
  endtask

  always @(negedge clk)
    if (!a_rst) mon(0, a_wen, a_ready, a_wdone, int'(a_wch), int'(a_wrow), int'(a_wcol),
                    72'(a_wdata), a_nn_ip, a_nn_mac, a_nn_port);
  always @(negedge clk)
    if (!b_rst) mon(1, b_wen, b_ready, b_wdone, int'(b_wch), int'(b_wrow), int'(b_wcol),
                    b_wdata, b_nn_ip, b_nn_mac, b_nn_port);

  task automatic tick();
    @(posedge clk);
    #1;
    if (rmode) begin
      rcnt++;
      a_ready = (rcnt % 4 == 0) || (rcnt % 4 == 3);
    end
  endtask

  task automatic send(input int w, input int pat, input logic [31:0] ip, input logic [47:0] mac,
                      input logic [15:0] port, input bit exp_acc);
    if (w == 0) begin
      for (int i = 0; i < A_BYTES; i++) a_frame[i*8 +: 8] = 8'(pbyte(pat, i));
      a_ip = ip; a_mac = mac; a_port = port; a_fr = 1'b1;
      if (exp_acc) push_frame(0, 28, 28, 1, 1, pat, ip, mac, port);
    end else begin
      for (int i = 0; i < B_BYTES; i++) b_frame[i*8 +: 8] = 8'(pbyte(pat, i));
      b_ip = ip; b_mac = mac; b_port = port; b_fr = 1'b1;
      if (exp_acc) push_frame(1, 4, 8, 3, 4, pat, ip, mac, port);
    end
    tick();
    a_fr = 1'b0;
    b_fr = 1'b0;
    if (w == 0) begin
      chk("frame_accept", a_acc, exp_acc);
      chk("frame_drop", a_drop, !exp_acc);
    end else begin
      chk("frame_accept_b", b_acc, exp_acc);
      chk("frame_drop_b", b_drop, 1'b0);
    end
  endtask

  task automatic wait_idle(input int w, input int budget);
    int c = 0;
    while ((sb[w].size() != 0 || done_due[w]) && c < budget) begin
      tick();
      c++;
    end
    chk("idle_timeout", (c < budget), 1'b1);
  endtask

  task automatic wait_beats(input int w, input int n, input int budget);
    int c = 0;
    while (beats[w] < n && c < budget) begin
      tick();
      c++;
    end
    chk("beat_timeout", (c < budget), 1'b1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    a_rst = 1'b1; b_rst = 1'b1; a_fr = 1'b0; b_fr = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
    a_frame = '0; b_frame = '0; a_ip = '0; a_mac = '0; a_port = '0;
    b_ip = '0; b_mac = '0; b_port = '0;
    repeat (3) tick();
    a_rst = 1'b0; b_rst = 1'b0;
    chk("reset_a", {a_acc, a_drop, a_busy, a_nn_ip, a_nn_mac, a_nn_port, a_wdata, a_wen,
                    a_wch, a_wrow, a_wcol, a_wdone}, '0);
    chk("reset_b", {b_acc, b_drop, b_busy, b_nn_ip, b_nn_mac, b_nn_port, b_wdata, b_wen,
                    b_wch, b_wrow, b_wcol, b_wdone}, '0);

    // Default frame, W_READY held high
    beats[0] = 0;
    send(0, 0, 32'h01020304, 48'hdeadbeefb00b, 16'd666, 1'b1);
    chk("pin_b28", {sb[0][28].row, sb[0][28].col, sb[0][28].data}, {32'd1, 32'd0, 72'd4});
    chk("pin_b100", {sb[0][100].row, sb[0][100].col, sb[0][100].data}, {32'd3, 32'd16, 72'd76});
    chk("pin_b783", {sb[0][783].row, sb[0][783].col, sb[0][783].data, sb[0][783].last},
        {32'd27, 32'd27, 72'd0, 1'b1});
    chk("first_wen", {a_wen, a_busy, a_wrow, a_wcol}, {2'b11, 10'd0});
    chk("src_nn", {a_nn_ip, a_nn_mac, a_nn_port}, {32'h01020304, 48'hdeadbeefb00b, 16'd666});
    wait_idle(0, 2000);
    chk("beats_t1", beats[0], 784);
    chk("idle_after", {a_busy, a_wen}, 2'b00);

    // Backpressure pattern 1,0,0,1
    beats[0] = 0;
    rmode = 1'b1;
    send(0, 0, 32'h01020304, 48'hdeadbeefb00b, 16'd666, 1'b1);
    wait_idle(0, 5000);
    rmode = 1'b0;
    a_ready = 1'b1;
    chk("beats_t2", beats[0], 784);

    // Multi-channel, four lanes
    beats[1] = 0;
    send(1, 1, 32'hc0a80001, 48'h001122334455, 16'd1234, 1'b1);
    chk("pin_bb5", {sb[1][5].ch, sb[1][5].row, sb[1][5].col, sb[1][5].data},
        {32'd0, 32'd2, 32'd4, 18'd92, 18'd88, 18'd84, 18'd80});
    chk("pin_bb23", {sb[1][23].ch, sb[1][23].row, sb[1][23].col, sb[1][23].data},
        {32'd2, 32'd3, 32'd4, 18'd380, 18'd376, 18'd372, 18'd368});
    wait_idle(1, 200);
    chk("beats_t3", beats[1], 24);

    // Second frame mid-stream
    beats[0] = 0;
    send(0, 0, 32'h01020304, 48'hdeadbeefb00b, 16'd666, 1'b1);
    wait_beats(0, 100, 200);
    send(0, 2, 32'h0a000002, 48'hbed1becc1122, 16'd999, PP);
    chk("src_after_2nd", {a_nn_mac, a_nn_port}, {48'hdeadbeefb00b, 16'd666});
    wait_idle(0, 3000);
    chk("beats_t4", beats[0], PP ? 1568 : 784);

    // Reset mid-stream
    beats[0] = 0;
    send(0, 0, 32'h01020304, 48'hdeadbeefb00b, 16'd666, 1'b1);
    wait_beats(0, 300, 400);
    a_rst = 1'b1;
    tick();
    sb[0].delete();
    done_due[0] = 1'b0;
    a_rst = 1'b0;
    chk("abort_out", {a_acc, a_drop, a_busy, a_nn_ip, a_nn_mac, a_nn_port, a_wdata, a_wen,
                      a_wch, a_wrow, a_wcol, a_wdone}, '0);
    repeat (3) begin
      tick();
      chk("abort_quiet", {a_wen, a_wdone}, 2'b00);
    end
    beats[0] = 0;
    send(0, 1, 32'h0a0b0c0d, 48'h0a0b0c0d0e0f, 16'd42, 1'b1);
    wait_idle(0, 2000);
    chk("beats_t5", beats[0], 784);

    // New frame offered in the DONE cycle
    beats[0] = 0;
    send(0, 0, 32'h01020304, 48'hdeadbeefb00b, 16'd666, 1'b1);
    begin
      int c = 0;
      while (sb[0].size() != 1 && c < 2000) begin
        tick();
        c++;
      end
      chk("last_beat_timeout", (c < 2000), 1'b1);
    end
    tick();
    chk("done_cycle", a_wdone, 1'b1);
    send(0, 2, 32'h0a000002, 48'hbed1becc1122, 16'd999, 1'b1);
    chk("restart_wen", {a_wen, a_wch, a_wrow, a_wcol}, {1'b1, 11'd0});
    wait_idle(0, 2000);
    chk("beats_t6", beats[0], 1568);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
